line_pattern_scanner: RTL and testbench

//  Parametrised, sequential successor to the combinational single-line chess-form judge.

---
 rtl/line_pattern_scanner.sv | 241 ++++++++++++++++++++++++
 tb/tb_line_pattern_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/line_pattern_scanner.sv
// rtl/line_pattern_scanner.sv - sequential per-channel line form classifier with start/done handshake
// Optional feature macro: PATTERN_SCORE_EN (weighted score accumulation).
module line_pattern_scanner #(
  parameter int HALF = 4,
  parameter int WIN  = 5,
  parameter int DIRS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [DIRS*(2*HALF+1)-1:0]                own,
  input  logic [DIRS*(2*HALF+1)-1:0]                opp,
  output logic                                      busy,
  output logic                                      done,
  output logic [2:0]                                type_max,
  output logic [((DIRS > 1) ? $clog2(DIRS) : 1)-1:0] dir_max,
  output logic [15:0]                               score
);

  localparam int LINE = 2*HALF + 1;
  localparam int NB   = DIRS*LINE;
  localparam int CW   = $clog2(HALF + 1);
  localparam int NW   = $clog2(LINE + 1);
  localparam int DW   = (DIRS > 1) ? $clog2(DIRS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN_L   = 3'd1;
  localparam logic [2:0] S_SCAN_R   = 3'd2;
  localparam logic [2:0] S_CLASSIFY = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [2:0] M_RUN  = 3'd0;
  localparam logic [2:0] M_GAP  = 3'd1;
  localparam logic [2:0] M_ADD  = 3'd2;
  localparam logic [2:0] M_TAIL = 3'd3;
  localparam logic [2:0] M_BLK  = 3'd4;

  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [NW-1:0] LINE_C = NW'(LINE);
  localparam logic [NW-1:0] CNT1_C = NW'(1);
  localparam logic [DW-1:0] LAST_C = DW'(DIRS - 1);
  localparam logic [NB-1:0] LSB_C  = NB'(1);
  localparam logic [7:0]    W0_C   = 8'(WIN);
  localparam logic [7:0]    W1_C   = 8'(WIN - 1);
  localparam logic [7:0]    W2_C   = 8'(WIN - 2);
  localparam logic [7:0]    W3_C   = 8'(WIN - 3);

  logic [2:0]    state;
  logic [CW-1:0] step;
  logic [DW-1:0] chan;
  logic [NB-1:0] own_q, opp_q;
  logic [2:0]    mark_l, mark_r;
  logic [CW-1:0] z_l, a_l, zc_l, z_r, a_r, zc_r;
  logic [NW-1:0] cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == HALF_C) ? x : x + 1'b1;
  endfunction

  assign busy = (state == S_SCAN_L) || (state == S_SCAN_R) || (state == S_CLASSIFY);
  assign done = (state == S_DONE);

  // Cell under inspection: left side walks down from centre, right side walks up.
  int   pos;
  logic cell_opp, cell_own;
  always_comb begin
    pos = int'(chan) * LINE +
          ((state == S_SCAN_L) ? (HALF - int'(step)) : (HALF + int'(step)));
    cell_opp = |((opp_q >> pos) & LSB_C);
    cell_own = |((own_q >> pos) & LSB_C) && !cell_opp;
  end

  logic [2:0]    cur_mark, nx_mark;
  logic [CW-1:0] cur_z, cur_a, cur_zc, nx_z, nx_a, nx_zc;
  logic [NW-1:0] nx_cnt;
  always_comb begin
    cur_mark = (state == S_SCAN_L) ? mark_l : mark_r;
    cur_z    = (state == S_SCAN_L) ? z_l    : z_r;
    cur_a    = (state == S_SCAN_L) ? a_l    : a_r;
    cur_zc   = (state == S_SCAN_L) ? zc_l   : zc_r;
    nx_mark  = cur_mark;
    nx_z     = cur_z;
    nx_a     = cur_a;
    nx_zc    = cur_zc;
    nx_cnt   = cnt;
    case (cur_mark)
      M_RUN: begin
        if (cell_opp)      nx_mark = M_BLK;
        else if (cell_own) nx_cnt  = (cnt == LINE_C) ? cnt : cnt + 1'b1;
        else begin nx_mark = M_GAP; nx_z = ONE_C; end
      end
      M_GAP: begin
        if (cell_opp)      nx_mark = M_BLK;
        else if (cell_own) begin nx_mark = M_ADD; nx_a = ONE_C; end
        else               nx_z = sat_inc(cur_z);
      end
      M_ADD: begin
        if (cell_opp)      nx_mark = M_BLK;
        else if (cell_own) nx_a = sat_inc(cur_a);
        else begin nx_mark = M_TAIL; nx_zc = ONE_C; end
      end
      M_TAIL: begin
        if (cell_opp || cell_own) nx_mark = M_BLK;
        else                      nx_zc = sat_inc(cur_zc);
      end
      default: nx_mark = M_BLK;
    endcase
  end

  // Form classification for the channel just scanned; first matching rule wins.
  logic [7:0] c8, zl, zr, al, ar, zcl, zcr;
  logic [2:0] cls;
  always_comb begin
    c8  = 8'(cnt);
    zl  = 8'(z_l);  zr  = 8'(z_r);
    al  = 8'(a_l);  ar  = 8'(a_r);
    zcl = 8'(zc_l); zcr = 8'(zc_r);
    cls = 3'd0;
    if (c8 >= W0_C)
      cls = 3'd7;
    else if (c8 == W1_C)
      cls = (zl != 8'd0 && zr != 8'd0) ? 3'd6 : ((zl + zr != 8'd0) ? 3'd5 : 3'd0);
    else if ((zl == 8'd1 && c8 + al >= W1_C) || (zr == 8'd1 && c8 + ar >= W1_C))
      cls = 3'd5;
    else if (c8 == W2_C)
      cls = (zl != 8'd0 && zr != 8'd0 && zl + zr >= 8'd3) ? 3'd4 :
            ((zl + zr >= 8'd2) ? 3'd3 : 3'd0);
    else if (zl == 8'd1 && c8 + al == W2_C)
      cls = (zcl != 8'd0 && zr != 8'd0) ? 3'd4 : ((zcl + zr != 8'd0) ? 3'd3 : 3'd0);
    else if (zr == 8'd1 && c8 + ar == W2_C)
      cls = (zcr != 8'd0 && zl != 8'd0) ? 3'd4 : ((zcr + zl != 8'd0) ? 3'd3 : 3'd0);
    else if (c8 == W3_C)
      cls = (zl != 8'd0 && zr != 8'd0 && zl + zr >= 8'd4) ? 3'd2 :
            ((zl + zr >= 8'd3) ? 3'd1 : 3'd0);
  end

`ifdef PATTERN_SCORE_EN
  logic [15:0] score_q;
  logic [15:0] weight;
  logic [16:0] score_sum;
  always_comb begin
    case (cls)
      3'd1:    weight = 16'd1;
      3'd2:    weight = 16'd4;
      3'd3:    weight = 16'd8;
      3'd4:    weight = 16'd32;
      3'd5:    weight = 16'd64;
      3'd6:    weight = 16'd512;
      3'd7:    weight = 16'd4096;
      default: weight = 16'd0;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, weight};
  end
  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= '0;
      chan     <= '0;
      own_q    <= '0;
      opp_q    <= '0;
      mark_l   <= M_RUN;
      mark_r   <= M_RUN;
      z_l      <= '0; a_l <= '0; zc_l <= '0;
      z_r      <= '0; a_r <= '0; zc_r <= '0;
      cnt      <= CNT1_C;
      type_max <= 3'd0;
      dir_max  <= '0;
`ifdef PATTERN_SCORE_EN
      score_q  <= 16'h0000;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            own_q    <= own;
            opp_q    <= opp;
            type_max <= 3'd0;
            dir_max  <= '0;
`ifdef PATTERN_SCORE_EN
            score_q  <= 16'h0000;
`endif
            chan     <= '0;
            step     <= ONE_C;
            mark_l   <= M_RUN;
            mark_r   <= M_RUN;
            z_l      <= '0; a_l <= '0; zc_l <= '0;
            z_r      <= '0; a_r <= '0; zc_r <= '0;
            cnt      <= CNT1_C;
            state    <= S_SCAN_L;
          end
        end
        S_SCAN_L: begin
          mark_l <= nx_mark; z_l <= nx_z; a_l <= nx_a; zc_l <= nx_zc;
          cnt    <= nx_cnt;
          if (step == HALF_C) begin
            step  <= ONE_C;
            state <= S_SCAN_R;
          end else begin
            step  <= step + 1'b1;
          end
        end
        S_SCAN_R: begin
          mark_r <= nx_mark; z_r <= nx_z; a_r <= nx_a; zc_r <= nx_zc;
          cnt    <= nx_cnt;
          if (step == HALF_C) state <= S_CLASSIFY;
          else                step  <= step + 1'b1;
        end
        S_CLASSIFY: begin
          if (cls > type_max) begin
            type_max <= cls;
            dir_max  <= chan;
          end
`ifdef PATTERN_SCORE_EN
          score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
          if (chan == LAST_C) begin
            state <= S_DONE;
          end else begin
            chan   <= chan + 1'b1;
            step   <= ONE_C;
            mark_l <= M_RUN;
            mark_r <= M_RUN;
            z_l    <= '0; a_l <= '0; zc_l <= '0;
            z_r    <= '0; a_r <= '0; zc_r <= '0;
            cnt    <= CNT1_C;
            state  <= S_SCAN_L;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_pattern_scanner.sv
// tb/tb_line_pattern_scanner.sv - randomized and directed bench for line_pattern_scanner
module tb_line_pattern_scanner;
  localparam int HALF = 4;
  localparam int WIN  = 5;
  localparam int DIRS = 4;
  localparam int LINE = 2*HALF + 1;
  localparam int NB   = DIRS*LINE;
  localparam int LAT  = DIRS*LINE + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] own = '0;
  logic [NB-1:0] opp = '0;
  logic          busy, done;
  logic [2:0]    type_max;
  logic [1:0]    dir_max;
  logic [15:0]   score;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_pattern_scanner #(.HALF(HALF), .WIN(WIN), .DIRS(DIRS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .own(own), .opp(opp),
    .busy(busy), .done(done), .type_max(type_max), .dir_max(dir_max), .score(score)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NB-1:0];
  endfunction

  function automatic int lit_score(input int s);
`ifdef PATTERN_SCORE_EN
    return s;
`else
    return 0 * s;
`endif
  endfunction

  function automatic int weight(input int t);
    case (t)
      1: return 1;    2: return 4;   3: return 8;    4: return 32;
      5: return 64;   6: return 512; 7: return 4096; default: return 0;
    endcase
  endfunction

  // Line described as segment lengths per side: run, gap, add-on, tail gap.
  function automatic int classify(input logic [LINE-1:0] ol, input logic [LINE-1:0] pl);
    int k[HALF];
    int z[2], a[2], zc[2];
    int cnt, i, p;
    cnt = 1;
    for (int sd = 0; sd < 2; sd++) begin
      for (int j = 0; j < HALF; j++) begin
        p = (sd == 0) ? HALF - 1 - j : HALF + 1 + j;
        if (((pl >> p) & 1) != 0)      k[j] = 2;
        else if (((ol >> p) & 1) != 0) k[j] = 1;
        else                           k[j] = 0;
      end
      i = 0; z[sd] = 0; a[sd] = 0; zc[sd] = 0;
      while (i < HALF && k[i] == 1) begin cnt++; i++; end
      while (i < HALF && k[i] == 0) begin z[sd]++; i++; end
      if (z[sd] > 0) while (i < HALF && k[i] == 1) begin a[sd]++; i++; end
      if (a[sd] > 0) while (i < HALF && k[i] == 0) begin zc[sd]++; i++; end
    end
    if (cnt >= WIN) return 7;
    if (cnt == WIN-1) return (z[0] >= 1 && z[1] >= 1) ? 6 : ((z[0] + z[1] >= 1) ? 5 : 0);
    if ((z[0] == 1 && cnt + a[0] >= WIN-1) || (z[1] == 1 && cnt + a[1] >= WIN-1)) return 5;
    if (cnt == WIN-2)
      return (z[0] >= 1 && z[1] >= 1 && z[0] + z[1] >= 3) ? 4 : ((z[0] + z[1] >= 2) ? 3 : 0);
    if (z[0] == 1 && cnt + a[0] == WIN-2)
      return (zc[0] >= 1 && z[1] >= 1) ? 4 : ((zc[0] + z[1] >= 1) ? 3 : 0);
    if (z[1] == 1 && cnt + a[1] == WIN-2)
      return (zc[1] >= 1 && z[0] >= 1) ? 4 : ((zc[1] + z[0] >= 1) ? 3 : 0);
    if (cnt == WIN-3)
      return (z[0] >= 1 && z[1] >= 1 && z[0] + z[1] >= 4) ? 2 : ((z[0] + z[1] >= 3) ? 1 : 0);
    return 0;
  endfunction

  task automatic model(input logic [NB-1:0] o, input logic [NB-1:0] p,
                       output int t, output int d, output int s);
    int c;
    t = 0; d = 0; s = 0;
    for (int ch = 0; ch < DIRS; ch++) begin
      c = classify(o[ch*LINE +: LINE], p[ch*LINE +: LINE]);
      if (c > t) begin t = c; d = ch; end
      s += weight(c);
    end
    if (s > 65535) s = 65535;
    s = lit_score(s);
  endtask

  task automatic run_scan(input string tag, input logic [NB-1:0] o, input logic [NB-1:0] p,
                          input bit repulse, input int lt, input int ld, input int ls);
    int mt, md, ms, lat;
    bit seen;
    model(o, p, mt, md, ms);
    own = o; opp = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; seen = 1'b0;
    while (!seen && lat <= LAT + 20) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        check({tag, " busy"}, busy, 1);
        own = rand_vec(); opp = rand_vec();
        start = repulse && (lat == 5 || lat == 20);
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
      end
    end
    check({tag, " latency"}, lat, LAT);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " type_max"}, type_max, mt);
    check({tag, " dir_max"}, dir_max, md);
    check({tag, " score"}, score, ms);
    if (lt >= 0) begin
      check({tag, " type_max literal"}, type_max, lt);
      check({tag, " dir_max literal"}, dir_max, ld);
      check({tag, " score literal"}, score, lit_score(ls));
    end
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " type_max held"}, type_max, mt);
  endtask

  initial begin
    logic [NB-1:0] o, p;
    int mode;
    bit any_done;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset type_max", type_max, 0);
    check("reset dir_max", dir_max, 0);
    check("reset score", score, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    o = '0; p = '0; o[2] = 1; o[3] = 1; o[5] = 1; o[6] = 1;
    run_scan("five", o, p, 1'b1, 7, 0, 4096);

    o = '0; p = '0; o[18+3] = 1; o[18+5] = 1;
    run_scan("live three", o, p, 1'b0, 4, 2, 32);

    o = '0; p = '0;
    o[10] = 1; o[11] = 1; o[12] = 1; p[9] = 1;
    o[28] = 1; o[29] = 1; o[30] = 1; p[27] = 1;
    run_scan("rush four tie", o, p, 1'b0, 5, 1, 128);

    o = '0; p = '0; o[2] = 1; o[5] = 1;
    run_scan("split three", o, p, 1'b0, 4, 0, 32);
    p[6] = 1;
    run_scan("split three blocked", o, p, 1'b0, 3, 0, 8);

    own = rand_vec(); opp = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midscan reset busy", busy, 0);
    check("midscan reset done", done, 0);
    check("midscan reset type_max", type_max, 0);
    check("midscan reset dir_max", dir_max, 0);
    check("midscan reset score", score, 0);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) any_done = 1'b1;
    end
    check("no done after reset", any_done, 0);
    o = '0; p = '0; o[2] = 1; o[3] = 1; o[5] = 1; o[6] = 1;
    run_scan("five after reset", o, p, 1'b0, 7, 0, 4096);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0)      o = rand_vec();
      else if (mode == 1) o = rand_vec() & rand_vec();
      else                o = rand_vec() | rand_vec();
      p = rand_vec() & rand_vec() & rand_vec();
      if (mode == 2) p = p & rand_vec();
      run_scan("random", o, p, n[0], -1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
